// File: rtl/dvi_pmod_dither_out.sv
// dvi_pmod_dither_out: DVI Pmod output stage that reduces IN_BITS colour
// to OUT_BITS per channel. It truncates, applies 2x2 Bayer dither, or
// applies spatio-temporal dither that rotates the threshold each frame.
// Two register stages are used. Sync and enable are delayed to match the
// colour path. Colour is forced to zero outside the active area.
//
// Ports:
//   i_pixclk, i_rst          pixel clock, synchronous active-high reset
//   i_hs, i_vs, i_de         sync / display enable from timing generator
//   i_frame                  one-cycle frame-start pulse (advances phase)
//   i_x, i_y                 pixel position (only bit 0 used)
//   i_red/i_green/i_blue     input colour, IN_BITS each
//   o_hs, o_vs, o_de         sync / enable delayed by 2
//   o_red/o_green/o_blue     reduced colour, OUT_BITS each
//   o_phase                  current temporal dither phase
module dvi_pmod_dither_out #(
    parameter int   IN_BITS  = 8,
    parameter int   OUT_BITS = 4,
    parameter int   DITHER   = 1,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic                i_pixclk,
    input  logic                i_rst,
    input  logic                i_hs,
    input  logic                i_vs,
    input  logic                i_de,
    input  logic                i_frame,
    input  logic [15:0]         i_x,
    input  logic [15:0]         i_y,
    input  logic [IN_BITS-1:0]  i_red,
    input  logic [IN_BITS-1:0]  i_green,
    input  logic [IN_BITS-1:0]  i_blue,
    output logic                o_hs,
    output logic                o_vs,
    output logic                o_de,
    output logic [OUT_BITS-1:0] o_red,
    output logic [OUT_BITS-1:0] o_green,
    output logic [OUT_BITS-1:0] o_blue,
    output logic [1:0]          o_phase
);
    localparam int D = IN_BITS - OUT_BITS;

    // Only the LSBs of the position select the Bayer cell.
    logic unused_xy;
    assign unused_xy = ^{i_x[15:1], i_y[15:1]};

    // Frame phase counter. Wraps 3 -> 0.
    logic [1:0] phase_q, phase_d;
    always_comb phase_d = i_frame ? phase_q + 2'd1 : phase_q;

    // Threshold selection.
    logic [1:0] tbase, tsel_d;
    always_comb begin
        case ({i_y[0], i_x[0]})
            2'b00:   tbase = 2'd0;
            2'b01:   tbase = 2'd2;
            2'b10:   tbase = 2'd3;
            default: tbase = 2'd1;
        endcase
        if (DITHER == 2)      tsel_d = tbase + phase_q;
        else if (DITHER == 1) tsel_d = tbase;
        else                  tsel_d = 2'd0;
    end

    // Stage 1 registers.
    logic               hs1_q, vs1_q, de1_q;
    logic [IN_BITS-1:0] r1_q, g1_q, b1_q;
    logic [1:0]         t1_q;

    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            phase_q <= 2'd0;
            hs1_q   <= ~H_POL;
            vs1_q   <= ~V_POL;
            de1_q   <= 1'b0;
            r1_q    <= '0;
            g1_q    <= '0;
            b1_q    <= '0;
            t1_q    <= 2'd0;
        end else begin
            phase_q <= phase_d;
            hs1_q   <= i_hs;
            vs1_q   <= i_vs;
            de1_q   <= i_de;
            r1_q    <= i_red;
            g1_q    <= i_green;
            b1_q    <= i_blue;
            t1_q    <= tsel_d;
        end
    end

    // Scale the 2-bit threshold into the bits discarded by truncation.
    logic [IN_BITS-1:0] off;
    generate
        if (D >= 2) begin : g_off_shift
            assign off = IN_BITS'(t1_q) << (D - 2);
        end else if (D == 1) begin : g_off_half
            logic unused_t;
            assign unused_t = t1_q[0];
            assign off = IN_BITS'(t1_q[1]);
        end else begin : g_off_none
            logic unused_t;
            assign unused_t = ^t1_q;
            assign off = '0;
        end
    endgenerate

    // The sum is one bit wider than the colour. A carry out saturates the
    // output so that bright pixels do not wrap to black.
    function automatic logic [OUT_BITS-1:0] reduce(input logic [IN_BITS-1:0] c,
                                                   input logic [IN_BITS-1:0] o);
        logic [IN_BITS:0] s;
        s = {1'b0, c} + {1'b0, o};
        if (s[IN_BITS]) reduce = '1;
        else            reduce = s[IN_BITS-1:D];
    endfunction

    logic [OUT_BITS-1:0] r2_d, g2_d, b2_d;
    always_comb begin
        r2_d = '0;
        g2_d = '0;
        b2_d = '0;
        if (de1_q) begin
            r2_d = reduce(r1_q, off);
            g2_d = reduce(g1_q, off);
            b2_d = reduce(b1_q, off);
        end
    end

    // Stage 2 registers drive the pins directly.
    always_ff @(posedge i_pixclk) begin
        if (i_rst) begin
            o_hs    <= ~H_POL;
            o_vs    <= ~V_POL;
            o_de    <= 1'b0;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else begin
            o_hs    <= hs1_q;
            o_vs    <= vs1_q;
            o_de    <= de1_q;
            o_red   <= r2_d;
            o_green <= g2_d;
            o_blue  <= b2_d;
        end
    end

    assign o_phase = phase_q;
endmodule
